conv_window_builder: RTL and testbench
======================================

Name: conv_window_builder

Overview:
- Upstream neighbour of the convolution stage: turns a raster-order stream of 4-bit grayscale pixels into 5x5 neighbourhood windows.
- Output is a 100-bit data_chunk plus a one-cycle data_ready strobe, matching the convolution stage's input contract.
- Uses 4 line buffers (one image row each) and a 5x5 register window.
- Emits one window per input pixel once the window is fully inside the image. Border pixels produce no window.

Parameters:
IMG_WIDTH, 640, pixels per row (>= 5)
IMG_HEIGHT, 480, rows per frame (>= 5)
PIX_W, 4, bits per pixel; data_chunk width = 25*PIX_W

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
frame_start  input  1  synchronous frame restart; clears row/col counters
pixel_valid  input  1  pixel_in is valid this cycle; no backpressure
pixel_in  input  PIX_W  grayscale pixel, raster order
data_ready  output  1  one-cycle strobe: data_chunk holds a new window
data_chunk  output  25*PIX_W  5x5 window, packed as below
center_x  output  $clog2(IMG_WIDTH)  column of the window centre pixel
center_y  output  $clog2(IMG_HEIGHT)  row of the window centre pixel
frame_done  output  1  one-cycle strobe after the last pixel of the frame is accepted

Behaviour:
- Clock is clk. Reset is reset, asynchronous, active-high.
- Reset values: data_ready=0, data_chunk=0, center_x=0, center_y=0, frame_done=0, col=0, row=0, window registers=0. Line-buffer RAM is not reset; output gating makes stale contents invisible.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on an accepted pixel (pixel_valid=1).
  - col wraps to 0 and row increments.
  - After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0 automatically.
- frame_start=1 forces col=row=0 before the same cycle's pixel is processed. With pixel_valid=1 in that cycle, the pixel is pixel (0,0) and the counters become col=1, row=0.
- Line buffers lb0..lb3 hold the pixels 1..4 rows above the current pixel. On an accepted pixel at column col:
  - read lb0[col]..lb3[col];
  - write lb0[col]=pixel_in, lb(k+1)[col]=old lbk[col];
  - new window column (top to bottom) = lb3, lb2, lb1, lb0, pixel_in.
- Window: 5 columns x 5 rows of registers. On each accepted pixel, columns shift left by one and the new column enters at c=4. The window is not cleared at row start; gating handles stale columns.
- Packing: window element at row r (0=top/oldest), column c (0=left/oldest) occupies data_chunk[(r*5+c)*PIX_W +: PIX_W]. The centre (r=2,c=2) is therefore bits [51:48] for PIX_W=4.
- Emission condition: accepted pixel with row>=4 and col>=4 (counter values before increment).
- Latency: data_ready rises 1 clk after the accepting edge and stays high for exactly 1 cycle per emitted window.
  - data_chunk, center_x = col-2, center_y = row-2 update in the same cycle as data_ready.
  - All three hold their values while data_ready=0.
- Windows per frame: (IMG_WIDTH-4)*(IMG_HEIGHT-4). No data_ready for border positions.
- frame_done: 1-cycle strobe, 1 clk after the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted. It coincides with that pixel's data_ready.
- pixel_valid gaps: no state changes; counters, window and outputs hold.
- frame_start mid-frame: counters restart. The next 4 rows emit nothing, so stale line-buffer data never appears on the output.
- Reset mid-frame: all state listed above clears immediately. The next pixel is (0,0).
- Line buffers: single-port RAM per buffer (read-before-write same address) or registers. Either choice is acceptable if the 1-cycle output latency holds.

Test Plan:
1. IMG_WIDTH=8, IMG_HEIGHT=6, reset, frame_start, then 48 continuous pixels with value (r*8+c) mod 16 -> exactly 8 data_ready pulses. First pulse 1 clk after pixel (4,4) is accepted, with center_x=2, center_y=2, data_chunk[51:48]=2, [3:0]=0, [99:96]=4.
2. Same frame, last window -> center_x=5, center_y=3, data_chunk[51:48]=(3*8+5) mod 16=13. frame_done asserted in the same cycle, one pulse only.
3. Same stream with pixel_valid deasserted every other cycle -> identical data_chunk/center sequence to test 1. data_ready never asserted in two consecutive cycles. Outputs stable during gaps.
4. Two back-to-back frames without frame_start -> second frame emits 8 windows identical to the first. Counters wrap from (7,5) to (0,0).
5. frame_start at pixel (3,2) mid-frame, then a full 48-pixel frame -> no data_ready until new pixel (4,4). Then 8 correct windows, none containing pre-restart data.
6. Assert reset for 2 cycles mid-frame (after 20 pixels) -> all outputs 0 immediately and asynchronously. A following full frame produces the test-1 results.

Source files
------------

// File: rtl/conv_window_builder_if.sv
// Pixel-stream in / 5x5 window out bundle for the window builder.
// Latency: none (wires only).
// Backpressure: none; the pixel source never stalls and windows are strobed.
interface conv_window_builder_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 4
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic                 frame_start;
  logic                 pixel_valid;
  logic [PIX_W-1:0]     pixel_in;
  logic                 data_ready;
  logic [25*PIX_W-1:0]  data_chunk;
  logic [CW-1:0]        center_x;
  logic [RW-1:0]        center_y;
  logic                 frame_done;

  // Pixel source / window consumer side.
  modport master (
    output frame_start, pixel_valid, pixel_in,
    input  data_ready, data_chunk, center_x, center_y, frame_done
  );

  // Window builder side.
  modport slave (
    input  frame_start, pixel_valid, pixel_in,
    output data_ready, data_chunk, center_x, center_y, frame_done
  );
endinterface

// File: rtl/conv_window_builder.sv
// Raster pixel stream -> 5x5 neighbourhood windows via 4 line buffers and a 5x5 register window.
// Latency: window, centre and frame_done are registered 1 clk after the accepting edge.
// Backpressure: none; pixel_valid gaps simply freeze all state.
module conv_window_builder #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_window_builder_if.slave  bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]        col, col_e;
  logic [RW-1:0]        row, row_e;
  logic [PIX_W-1:0]     lb      [4][IMG_WIDTH];
  logic [PIX_W-1:0]     win     [5][5];
  logic [PIX_W-1:0]     win_n   [5][5];
  logic [PIX_W-1:0]     new_col [5];
  logic [25*PIX_W-1:0]  chunk_n;
  logic                 accept, emit, last_pix;

  // Effective position of this cycle's pixel: frame_start restarts at (0,0) before processing.
  always_comb begin
    col_e    = bus.frame_start ? '0 : col;
    row_e    = bus.frame_start ? '0 : row;
    accept   = bus.pixel_valid;
    emit     = accept && (row_e >= RW'(4)) && (col_e >= CW'(4));
    last_pix = (col_e == CW'(IMG_WIDTH - 1)) && (row_e == RW'(IMG_HEIGHT - 1));
  end

  // New window column, oldest row on top; line buffers are read before this edge's write.
  always_comb begin
    new_col[0] = lb[3][col_e];
    new_col[1] = lb[2][col_e];
    new_col[2] = lb[1][col_e];
    new_col[3] = lb[0][col_e];
    new_col[4] = bus.pixel_in;
  end

  // Next window: shift columns left, insert the new column at the right, and pack it.
  always_comb begin
    chunk_n = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        win_n[r][c] = win[r][c+1];
      end
      win_n[r][4] = new_col[r];
      for (int c = 0; c < 5; c++) begin
        chunk_n[(r*5+c)*PIX_W +: PIX_W] = win_n[r][c];
      end
    end
  end

  // Raster position counters; wrap at end of row and end of frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_e == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row_e == RW'(IMG_HEIGHT - 1)) ? '0 : row_e + RW'(1);
      end else begin
        col <= col_e + CW'(1);
        row <= row_e;
      end
    end else if (bus.frame_start) begin
      col <= '0;
      row <= '0;
    end
  end

  // Line buffers cascade one row down per accepted pixel; contents are never reset
  // because windows touching rows not yet written this frame are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][col_e] <= bus.pixel_in;
      lb[1][col_e] <= lb[0][col_e];
      lb[2][col_e] <= lb[1][col_e];
      lb[3][col_e] <= lb[2][col_e];
    end
  end

  // Window registers advance only on accepted pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win <= win_n;
    end
  end

  // Output strobes plus held window/centre, updated only when a window is emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data_ready <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.data_chunk <= '0;
      bus.center_x   <= '0;
      bus.center_y   <= '0;
    end else begin
      bus.data_ready <= emit;
      bus.frame_done <= accept && last_pix;
      if (emit) begin
        bus.data_chunk <= chunk_n;
        bus.center_x   <= col_e - CW'(2);
        bus.center_y   <= row_e - RW'(2);
      end
    end
  end
endmodule

// File: tb/tb_conv_window_builder.sv
module tb_conv_window_builder;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 4;
  localparam int CXW = $clog2(W);
  localparam int CYW = $clog2(H);
  localparam int VW  = 2 + CXW + CYW + 25*PW;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  conv_window_builder_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) bus ();

  conv_window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the frame is kept as a 2-D image; a window is just the
  // 5x5 block of the image ending at the pixel just accepted.
  logic [PW-1:0]      img [H][W];
  int                 mr, mc;
  logic               exp_ready, exp_done;
  logic [CXW-1:0]     exp_cx;
  logic [CYW-1:0]     exp_cy;
  logic [25*PW-1:0]   exp_chunk;
  logic [VW-1:0]      got, want;

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_ready = 0; exp_done = 0; exp_cx = '0; exp_cy = '0; exp_chunk = '0;
  endtask

  // Drive one cycle, update the model on the edge, return 1 time unit later.
  task automatic step(input bit v, input bit fs, input logic [PW-1:0] p);
    bus.pixel_valid = v;
    bus.frame_start = fs;
    bus.pixel_in    = p;
    @(posedge clk);
    if (fs) begin mr = 0; mc = 0; end
    exp_ready = 0;
    exp_done  = 0;
    if (v) begin
      img[mr][mc] = p;
      if (mr >= 4 && mc >= 4) begin
        exp_ready = 1;
        exp_cx = CXW'(mc - 2);
        exp_cy = CYW'(mr - 2);
        for (int wr = 0; wr < 5; wr++)
          for (int wc = 0; wc < 5; wc++)
            exp_chunk[(wr*5+wc)*PW +: PW] = img[mr-4+wr][mc-4+wc];
      end
      exp_done = (mr == H-1) && (mc == W-1);
      mc++;
      if (mc == W) begin mc = 0; mr++; if (mr == H) mr = 0; end
    end
    #1;
    got  = {bus.data_ready, bus.frame_done, bus.center_x, bus.center_y, bus.data_chunk};
    want = {exp_ready, exp_done, exp_cx, exp_cy, exp_chunk};
  endtask

  function automatic logic [PW-1:0] pat(input int i);
    return PW'(((i / W) * W + (i % W)) % 16);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.pixel_valid = 0; bus.frame_start = 0; bus.pixel_in = '0;
    #3;
    checks++;
    if ({bus.data_ready, bus.frame_done, bus.center_x, bus.center_y, bus.data_chunk} !== '0) begin
      errors++;
      $display("FAIL reset_state got %h want 0",
               {bus.data_ready, bus.frame_done, bus.center_x, bus.center_y, bus.data_chunk});
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_frame();
    int pulses = 0, dones = 0;
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, pat(i));
      checks++;
      if (got !== want) begin errors++; $display("FAIL frame cyc %0d got %h want %h", i, got, want); end
      if (bus.data_ready === 1'b1 && pulses == 0) begin
        checks++;
        if (bus.center_x !== 2 || bus.center_y !== 2) begin
          errors++; $display("FAIL first_centre got %0d,%0d want 2,2", bus.center_x, bus.center_y);
        end
        checks++;
        if (bus.data_chunk[51:48] !== 4'd2 || bus.data_chunk[3:0] !== 4'd0 || bus.data_chunk[99:96] !== 4'd4) begin
          errors++; $display("FAIL first_chunk got %h/%h/%h want 2/0/4",
                             bus.data_chunk[51:48], bus.data_chunk[3:0], bus.data_chunk[99:96]);
        end
      end
      if (bus.frame_done === 1'b1) begin
        dones++;
        checks++;
        if (bus.data_ready !== 1'b1 || bus.center_x !== 5 || bus.center_y !== 3 || bus.data_chunk[51:48] !== 4'd13) begin
          errors++; $display("FAIL last_window got rdy %0b c %0d,%0d pix %0d want 1 5,3 13",
                             bus.data_ready, bus.center_x, bus.center_y, bus.data_chunk[51:48]);
        end
      end
      if (bus.data_ready === 1'b1) pulses++;
    end
    step(0, 0, '0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL frame_idle got %h want %h", got, want); end
    checks++;
    if (pulses != (W-4)*(H-4) || dones != 1) begin
      errors++; $display("FAIL frame_counts got %0d/%0d want %0d/1", pulses, dones, (W-4)*(H-4));
    end
  endtask

  task automatic test_gaps();
    int pulses = 0;
    bit prev = 0;
    for (int i = 0; i < 2*W*H; i++) begin
      step(i % 2 == 0, i == 0, pat(i / 2));
      checks++;
      if (got !== want) begin errors++; $display("FAIL gaps cyc %0d got %h want %h", i, got, want); end
      checks++;
      if (prev && bus.data_ready === 1'b1) begin errors++; $display("FAIL gaps_consecutive cyc %0d got 1 want 0", i); end
      prev = (bus.data_ready === 1'b1);
      if (prev) pulses++;
    end
    checks++;
    if (pulses != (W-4)*(H-4)) begin errors++; $display("FAIL gaps_count got %0d want %0d", pulses, (W-4)*(H-4)); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, dones = 0;
    for (int i = 0; i < 2*W*H; i++) begin
      step(1, 0, PW'($urandom));
      checks++;
      if (got !== want) begin errors++; $display("FAIL b2b cyc %0d got %h want %h", i, got, want); end
      if (bus.data_ready === 1'b1) pulses++;
      if (bus.frame_done === 1'b1) dones++;
    end
    checks++;
    if (pulses != 2*(W-4)*(H-4) || dones != 2) begin
      errors++; $display("FAIL b2b_counts got %0d/%0d want %0d/2", pulses, dones, 2*(W-4)*(H-4));
    end
  endtask

  task automatic test_midframe_restart();
    int pulses = 0;
    for (int i = 0; i < 2*W + 3; i++) begin
      step($urandom_range(0, 3) != 0, i == 0, PW'($urandom));
    end
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, PW'($urandom));
      checks++;
      if (got !== want) begin errors++; $display("FAIL restart cyc %0d got %h want %h", i, got, want); end
      checks++;
      if (bus.data_ready === 1'b1 && i < 4*W + 4) begin
        errors++; $display("FAIL restart_early cyc %0d got 1 want 0", i);
      end
      if (bus.data_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != (W-4)*(H-4)) begin errors++; $display("FAIL restart_count got %0d want %0d", pulses, (W-4)*(H-4)); end
  endtask

  task automatic test_reset_midframe();
    int pulses = 0;
    for (int i = 0; i < 20; i++) step(1, 0, PW'($urandom));
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.data_ready, bus.frame_done, bus.center_x, bus.center_y, bus.data_chunk} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {bus.data_ready, bus.frame_done, bus.center_x, bus.center_y, bus.data_chunk});
    end
    bus.pixel_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < W*H; i++) begin
      step(1, 0, pat(i));
      checks++;
      if (got !== want) begin errors++; $display("FAIL post_reset cyc %0d got %h want %h", i, got, want); end
      if (bus.data_ready === 1'b1 && pulses == 0) begin
        checks++;
        if (bus.center_x !== 2 || bus.center_y !== 2 || bus.data_chunk[51:48] !== 4'd2) begin
          errors++; $display("FAIL post_reset_first got %0d,%0d pix %0d want 2,2 2",
                             bus.center_x, bus.center_y, bus.data_chunk[51:48]);
        end
      end
      if (bus.data_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != (W-4)*(H-4)) begin errors++; $display("FAIL post_reset_count got %0d want %0d", pulses, (W-4)*(H-4)); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_back_to_back();
    test_midframe_restart();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
